// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access-size encodings,
// responder FSM states and the wait-counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: load extract/extend, store byte-merge into the
// addressed doubleword, and natural-alignment check.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [63:0] rd_dword,
  input  logic [63:0] wdata,
  input  logic [2:0]  lane,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [63:0] load_data,
  output logic [63:0] merged_dword,
  output logic        misaligned
);

  logic [63:0] shifted_s;
  logic [63:0] wshift_s;
  logic [63:0] bitmask_s;
  logic [7:0]  base_mask_s;
  logic [7:0]  bytemask_s;

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted_s = rd_dword >> {lane, 3'b000};
    load_data = 64'd0;
    case (size)
      SZ_B: load_data = is_unsigned ? {56'd0, shifted_s[7:0]}
                                    : {{56{shifted_s[7]}}, shifted_s[7:0]};
      SZ_H: load_data = is_unsigned ? {48'd0, shifted_s[15:0]}
                                    : {{48{shifted_s[15]}}, shifted_s[15:0]};
      SZ_W: load_data = is_unsigned ? {32'd0, shifted_s[31:0]}
                                    : {{32{shifted_s[31]}}, shifted_s[31:0]};
      SZ_D: load_data = shifted_s;
      default: load_data = 64'd0;
    endcase
  end

  // Store path: only the bytes covered by the access are replaced.
  always_comb begin
    base_mask_s = 8'h00;
    case (size)
      SZ_B: base_mask_s = 8'h01;
      SZ_H: base_mask_s = 8'h03;
      SZ_W: base_mask_s = 8'h0F;
      SZ_D: base_mask_s = 8'hFF;
      default: base_mask_s = 8'h00;
    endcase
    bytemask_s = base_mask_s << lane;
    bitmask_s  = 64'd0;
    for (int i = 0; i < 8; i++) begin
      bitmask_s[i*8 +: 8] = {8{bytemask_s[i]}};
    end
    wshift_s     = wdata << {lane, 3'b000};
    merged_dword = (rd_dword & ~bitmask_s) | (wshift_s & bitmask_s);
  end

  // Natural alignment: address must be a multiple of the access size.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_B: misaligned = 1'b0;
      SZ_H: misaligned = lane[0];
      SZ_W: misaligned = |lane[1:0];
      SZ_D: misaligned = |lane;
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder with valid/ready requests and a one-cycle
// response pulse. Array contents are undefined until written.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int    DEPTH       = 256,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = "dmem.hex"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam state_e            ACC_STATE = (WAIT_CYCLES == 0) ? RESP : BUSY;
  localparam logic [WAIT_W-1:0] ACC_CNT   =
    (WAIT_CYCLES == 0) ? {WAIT_W{1'b0}} : WAIT_W'(WAIT_CYCLES - 1);

  logic [63:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              cap_write_q, cap_write_d;
  logic [63:0]       cap_addr_q, cap_addr_d;
  logic [63:0]       cap_wdata_q, cap_wdata_d;
  size_e             cap_size_q, cap_size_d;
  logic              cap_unsigned_q, cap_unsigned_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [63:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic          accept_s;
  logic          err_s;
  logic          misaligned_s;
  logic          mem_we_s;
  logic [AW-1:0] idx_s;
  logic [63:0]   load_s;
  logic [63:0]   merged_s;

  assign idx_s    = cap_addr_q[3 +: AW];
  assign accept_s = req_valid & req_ready_q;
  assign err_s    = misaligned_s | (cap_addr_q[63:3] >= 61'(DEPTH));

  dmem_lane_align u_lane (
    .rd_dword     (mem[idx_s]),
    .wdata        (cap_wdata_q),
    .lane         (cap_addr_q[2:0]),
    .size         (cap_size_q),
    .is_unsigned  (cap_unsigned_q),
    .load_data    (load_s),
    .merged_dword (merged_s),
    .misaligned   (misaligned_s)
  );

  // Next-state, capture and response computation.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cap_write_d    = cap_write_q;
    cap_addr_d     = cap_addr_q;
    cap_wdata_d    = cap_wdata_q;
    cap_size_d     = cap_size_q;
    cap_unsigned_d = cap_unsigned_q;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = resp_rdata_q;
    resp_err_d     = resp_err_q;
    mem_we_s       = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        if (state_q == RESP) begin
          // The response registers load as RESP is left, so the pulse follows RESP.
          resp_valid_d = 1'b1;
          resp_err_d   = err_s;
          mem_we_s     = cap_write_q & ~err_s;
          if (cap_write_q || err_s) begin
            resp_rdata_d = 64'd0;
          end else begin
            resp_rdata_d = load_s;
          end
        end else begin
          resp_valid_d = 1'b0;
        end
        if (accept_s) begin
          cap_write_d    = req_write;
          cap_addr_d     = req_addr;
          cap_wdata_d    = req_wdata;
          cap_size_d     = size_e'(req_size);
          cap_unsigned_d = req_unsigned;
          state_d        = ACC_STATE;
          cnt_d          = ACC_CNT;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == {WAIT_W{1'b0}}) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d != BUSY);
  end

  // Control and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= {WAIT_W{1'b0}};
      cap_write_q    <= 1'b0;
      cap_addr_q     <= 64'd0;
      cap_wdata_q    <= 64'd0;
      cap_size_q     <= SZ_B;
      cap_unsigned_q <= 1'b0;
      req_ready_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= 64'd0;
      resp_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cap_write_q    <= cap_write_d;
      cap_addr_q     <= cap_addr_d;
      cap_wdata_q    <= cap_wdata_d;
      cap_size_q     <= cap_size_d;
      cap_unsigned_q <= cap_unsigned_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_err_q     <= resp_err_d;
    end
  end

  // Storage array; never cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[idx_s] <= merged_s;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
